write_back: RTL and testbench

Final stage of the dual-issue pipeline, directly downstream of the memory stage. Each cycle it takes the memory stage's outputs: the 64-bit instruction pair, the upper/lower destination tags, the lower-slot ALU result, and the 64-bit data-RAM read word. It commits up to two results into the 32×32 general register file. It also serves four write-through read ports to decode and keeps a retired-instruction counter.

---
 rtl/write_back_pkg.sv | 16 +
 rtl/write_back_if.sv | 22 ++
 rtl/write_back_regfile_2w4r.sv | 40 ++++
 rtl/write_back.sv | 107 ++++++++++
 tb/tb_write_back.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_back_pkg.sv
// Shared pipeline definitions used by the write-back stage and its register file.
package write_back_pkg;

  localparam int NREG = 32;
  localparam int XLEN = 32;

  // Slot encoding the memory stage emits while the pipeline is interlocked.
  localparam logic [XLEN-1:0] NOP_SLOT = {3'b111, 29'b0};

  typedef logic [4:0] reg_idx_t;

  function automatic logic is_live(logic [XLEN-1:0] slot);
    return slot != NOP_SLOT;
  endfunction

endpackage

// File: rtl/write_back_if.sv
// Memory-stage to write-back bundle: instruction pair, destination tags and result data.
interface write_back_if;
  import write_back_pkg::*;

  logic [63:0]     inst;
  reg_idx_t        u_rt;
  logic            u_rt_flag;
  logic            u_word_sel;
  logic [63:0]     doutb;
  logic [XLEN-1:0] l_tdata;
  reg_idx_t        l_rt;
  logic            l_rt_flag;

  modport master (
    output inst, u_rt, u_rt_flag, u_word_sel, doutb, l_tdata, l_rt, l_rt_flag
  );

  modport slave (
    input inst, u_rt, u_rt_flag, u_word_sel, doutb, l_tdata, l_rt, l_rt_flag
  );

endinterface

// File: rtl/write_back_regfile_2w4r.sv
// 32x32 register file: two write ports where the lower (later) slot wins a tag
// collision, four write-through read ports, r0 reads zero, synchronous clear.
module regfile_2w4r
  import write_back_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            we_u_i,
  input  reg_idx_t        waddr_u_i,
  input  logic [XLEN-1:0] wdata_u_i,
  input  logic            we_l_i,
  input  reg_idx_t        waddr_l_i,
  input  logic [XLEN-1:0] wdata_l_i,
  input  reg_idx_t        raddr_i [4],
  output logic [XLEN-1:0] rdata_o [4]
);

  logic [XLEN-1:0] regs_q [NREG];

  // Lower write is issued after the upper one, so on equal tags it lands last.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (we_u_i && (waddr_u_i != '0)) regs_q[waddr_u_i] <= wdata_u_i;
      if (we_l_i && (waddr_l_i != '0)) regs_q[waddr_l_i] <= wdata_l_i;
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata_o[p] = '0;
      if (raddr_i[p] == '0)                          rdata_o[p] = '0;
      else if (we_l_i && (raddr_i[p] == waddr_l_i)) rdata_o[p] = wdata_l_i;
      else if (we_u_i && (raddr_i[p] == waddr_u_i)) rdata_o[p] = wdata_u_i;
      else                                           rdata_o[p] = regs_q[raddr_i[p]];
    end
  end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: commits up to two results per cycle, serves decode reads,
// drives the bypass registers and counts retired (non-NOP) instructions.
module write_back
  import write_back_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  write_back_if.slave     mem,
  input  reg_idx_t        ra0_addr,
  input  reg_idx_t        ra1_addr,
  input  reg_idx_t        rb0_addr,
  input  reg_idx_t        rb1_addr,
  output logic [XLEN-1:0] ra0_data,
  output logic [XLEN-1:0] ra1_data,
  output logic [XLEN-1:0] rb0_data,
  output logic [XLEN-1:0] rb1_data,
  output reg_idx_t        wb_u_rt,
  output reg_idx_t        wb_l_rt,
  output logic            wb_u_flag,
  output logic            wb_l_flag,
  output logic [XLEN-1:0] wb_u_data,
  output logic [XLEN-1:0] wb_l_data,
  output logic [31:0]     retired
);

  logic [XLEN-1:0] u_data;
  logic            u_we, l_we, u_shadowed;
  logic [1:0]      live_cnt;
  reg_idx_t        raddr [4];
  logic [XLEN-1:0] rdata [4];

  reg_idx_t        wb_u_rt_q, wb_u_rt_d, wb_l_rt_q, wb_l_rt_d;
  logic            wb_u_flag_q, wb_u_flag_d, wb_l_flag_q, wb_l_flag_d;
  logic [XLEN-1:0] wb_u_data_q, wb_u_data_d, wb_l_data_q, wb_l_data_d;
  logic [31:0]     retired_q, retired_d;

  assign u_data = mem.u_word_sel ? mem.doutb[63:32] : mem.doutb[31:0];

  // Gating with rstn keeps the write-through path quiet while reset is held.
  assign u_we       = rstn && mem.u_rt_flag && (mem.u_rt != '0);
  assign l_we       = rstn && mem.l_rt_flag && (mem.l_rt != '0);
  assign u_shadowed = u_we && l_we && (mem.u_rt == mem.l_rt);

  assign live_cnt = {1'b0, is_live(mem.inst[63:32])} + {1'b0, is_live(mem.inst[31:0])};

  assign raddr[0] = ra0_addr;
  assign raddr[1] = ra1_addr;
  assign raddr[2] = rb0_addr;
  assign raddr[3] = rb1_addr;

  regfile_2w4r u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .we_u_i    (u_we),
    .waddr_u_i (mem.u_rt),
    .wdata_u_i (u_data),
    .we_l_i    (l_we),
    .waddr_l_i (mem.l_rt),
    .wdata_l_i (mem.l_tdata),
    .raddr_i   (raddr),
    .rdata_o   (rdata)
  );

  assign ra0_data = rdata[0];
  assign ra1_data = rdata[1];
  assign rb0_data = rdata[2];
  assign rb1_data = rdata[3];

  always_comb begin
    wb_u_rt_d   = mem.u_rt;
    wb_l_rt_d   = mem.l_rt;
    wb_u_flag_d = u_we && !u_shadowed;
    wb_l_flag_d = l_we;
    wb_u_data_d = u_data;
    wb_l_data_d = mem.l_tdata;
    retired_d   = retired_q + {30'd0, live_cnt};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_u_rt_q   <= '0;
      wb_l_rt_q   <= '0;
      wb_u_flag_q <= 1'b0;
      wb_l_flag_q <= 1'b0;
      wb_u_data_q <= '0;
      wb_l_data_q <= '0;
      retired_q   <= '0;
    end else begin
      wb_u_rt_q   <= wb_u_rt_d;
      wb_l_rt_q   <= wb_l_rt_d;
      wb_u_flag_q <= wb_u_flag_d;
      wb_l_flag_q <= wb_l_flag_d;
      wb_u_data_q <= wb_u_data_d;
      wb_l_data_q <= wb_l_data_d;
      retired_q   <= retired_d;
    end
  end

  assign wb_u_rt   = wb_u_rt_q;
  assign wb_l_rt   = wb_l_rt_q;
  assign wb_u_flag = wb_u_flag_q;
  assign wb_l_flag = wb_l_flag_q;
  assign wb_u_data = wb_u_data_q;
  assign wb_l_data = wb_l_data_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed cases plus randomized traffic
// compared each cycle against an architectural register-file model.
module tb_write_back;
  import write_back_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  reg_idx_t    ra0_addr, ra1_addr, rb0_addr, rb1_addr;
  logic [31:0] ra0_data, ra1_data, rb0_data, rb1_data;
  reg_idx_t    wb_u_rt, wb_l_rt;
  logic        wb_u_flag, wb_l_flag;
  logic [31:0] wb_u_data, wb_l_data;
  logic [31:0] retired;

  write_back_if mem_if ();

  write_back dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem       (mem_if),
    .ra0_addr  (ra0_addr),
    .ra1_addr  (ra1_addr),
    .rb0_addr  (rb0_addr),
    .rb1_addr  (rb1_addr),
    .ra0_data  (ra0_data),
    .ra1_data  (ra1_data),
    .rb0_data  (rb0_data),
    .rb1_data  (rb1_data),
    .wb_u_rt   (wb_u_rt),
    .wb_l_rt   (wb_l_rt),
    .wb_u_flag (wb_u_flag),
    .wb_l_flag (wb_l_flag),
    .wb_u_data (wb_u_data),
    .wb_l_data (wb_l_data),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_retired;
  logic        m_u_flag, m_l_flag;
  reg_idx_t    m_u_rt, m_l_rt;
  logic [31:0] m_u_data, m_l_data;
  logic        m_payload_valid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] upper_value();
    return mem_if.u_word_sel ? mem_if.doutb[63:32] : mem_if.doutb[31:0];
  endfunction

  function automatic logic u_commits();
    return rstn && mem_if.u_rt_flag && (mem_if.u_rt != 5'd0);
  endfunction

  function automatic logic l_commits();
    return rstn && mem_if.l_rt_flag && (mem_if.l_rt != 5'd0);
  endfunction

  // What decode must see: the register after this cycle's commit.
  function automatic logic [31:0] exp_read(reg_idx_t a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_regs[a];
    if (u_commits() && a == mem_if.u_rt) v = upper_value();
    if (l_commits() && a == mem_if.l_rt) v = mem_if.l_tdata;
    return v;
  endfunction

  function automatic int live_slots();
    int n;
    n = 0;
    if (mem_if.inst[63:32] != NOP_SLOT) n++;
    if (mem_if.inst[31:0]  != NOP_SLOT) n++;
    return n;
  endfunction

  task automatic model_commit();
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_retired = 0; m_u_flag = 0; m_l_flag = 0;
      m_u_rt = 0; m_l_rt = 0; m_u_data = 0; m_l_data = 0;
      m_payload_valid = 1'b1;
    end else begin
      m_u_flag = u_commits() && !(l_commits() && mem_if.u_rt == mem_if.l_rt);
      m_l_flag = l_commits();
      m_u_rt = mem_if.u_rt; m_l_rt = mem_if.l_rt;
      m_u_data = upper_value(); m_l_data = mem_if.l_tdata;
      m_payload_valid = 1'b0;
      if (u_commits()) m_regs[mem_if.u_rt] = upper_value();
      if (l_commits()) m_regs[mem_if.l_rt] = mem_if.l_tdata;
      m_retired = m_retired + 32'(live_slots());
    end
  endtask

  task automatic check_reads();
    chk("ra0_data", ra0_data, exp_read(ra0_addr));
    chk("ra1_data", ra1_data, exp_read(ra1_addr));
    chk("rb0_data", rb0_data, exp_read(rb0_addr));
    chk("rb1_data", rb1_data, exp_read(rb1_addr));
  endtask

  task automatic check_outputs();
    chk("retired", retired, m_retired);
    chk("wb_u_flag", {31'd0, wb_u_flag}, {31'd0, m_u_flag});
    chk("wb_l_flag", {31'd0, wb_l_flag}, {31'd0, m_l_flag});
    if (m_u_flag || m_payload_valid) begin
      chk("wb_u_rt", {27'd0, wb_u_rt}, {27'd0, m_u_rt});
      chk("wb_u_data", wb_u_data, m_u_data);
    end
    if (m_l_flag || m_payload_valid) begin
      chk("wb_l_rt", {27'd0, wb_l_rt}, {27'd0, m_l_rt});
      chk("wb_l_data", wb_l_data, m_l_data);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #1 check_reads();
    @(posedge clk);
    #1;
    model_commit();
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_if.inst       = {NOP_SLOT, NOP_SLOT};
    mem_if.u_rt       = 5'($urandom_range(0, 31));
    mem_if.u_rt_flag  = 1'b0;
    mem_if.u_word_sel = 1'($urandom_range(0, 1));
    mem_if.doutb      = {$urandom, $urandom};
    mem_if.l_tdata    = $urandom;
    mem_if.l_rt       = 5'($urandom_range(0, 31));
    mem_if.l_rt_flag  = 1'b0;
  endtask

  function automatic reg_idx_t pick_addr();
    case ($urandom_range(0, 5))
      0: return mem_if.u_rt;
      1: return mem_if.l_rt;
      2: return 5'd0;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic random_inputs();
    logic [31:0] us, ls;
    us = ($urandom_range(0, 3) == 0) ? NOP_SLOT : $urandom;
    ls = ($urandom_range(0, 3) == 0) ? NOP_SLOT : $urandom;
    mem_if.inst       = {us, ls};
    mem_if.u_rt       = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    mem_if.l_rt       = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    mem_if.u_rt_flag  = (us != NOP_SLOT) && ($urandom_range(0, 3) != 0);
    mem_if.l_rt_flag  = (ls != NOP_SLOT) && ($urandom_range(0, 3) != 0);
    mem_if.u_word_sel = 1'($urandom_range(0, 1));
    mem_if.doutb      = {$urandom, $urandom};
    mem_if.l_tdata    = $urandom;
    ra0_addr = pick_addr(); ra1_addr = pick_addr();
    rb0_addr = pick_addr(); rb1_addr = pick_addr();
  endtask

  initial begin
    rstn = 1'b0;
    random_inputs();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_retired = 0;
    // Reset held for two edges with live-looking inputs.
    @(posedge clk);
    @(negedge clk);
    random_inputs();
    @(posedge clk);
    #1;
    model_commit();
    check_outputs();
    chk("reset_retired", retired, 32'd0);
    @(negedge clk);
    random_inputs();
    #1 check_reads();
    chk("reset_ra0", ra0_data, 32'd0);
    chk("reset_rb1", rb1_data, 32'd0);
    idle_inputs();
    rstn = 1'b1;
    cycle();

    // Dual commit with upper word select
    idle_inputs();
    mem_if.inst = {32'h0000_1111, 32'h0000_2222};
    mem_if.u_rt = 5'd3; mem_if.u_rt_flag = 1'b1; mem_if.u_word_sel = 1'b1;
    mem_if.doutb = 64'hAAAA_0000_1111_2222;
    mem_if.l_rt = 5'd4; mem_if.l_rt_flag = 1'b1; mem_if.l_tdata = 32'h55;
    cycle();
    chk("dual_retired", retired, 32'd2);
    idle_inputs();
    ra0_addr = 5'd3; ra1_addr = 5'd4;
    #1;
    chk("dual_r3", ra0_data, 32'hAAAA_0000);
    chk("dual_r4", ra1_data, 32'h0000_0055);
    cycle();

    // Same destination in both slots
    idle_inputs();
    mem_if.inst = {32'h1, 32'h2};
    mem_if.u_rt = 5'd7; mem_if.u_rt_flag = 1'b1;
    mem_if.l_rt = 5'd7; mem_if.l_rt_flag = 1'b1; mem_if.l_tdata = 32'h9;
    cycle();
    chk("same_wb_l_flag", {31'd0, wb_l_flag}, 32'd1);
    chk("same_wb_u_flag", {31'd0, wb_u_flag}, 32'd0);
    idle_inputs();
    rb0_addr = 5'd7;
    #1 chk("same_r7", rb0_data, 32'h9);
    cycle();

    // r0 target and a NOP upper slot
    idle_inputs();
    mem_if.inst = {NOP_SLOT, 32'h0000_0013};
    mem_if.l_rt = 5'd0; mem_if.l_rt_flag = 1'b1; mem_if.l_tdata = 32'hFFFF;
    rb1_addr = 5'd0;
    #1 chk("r0_through", rb1_data, 32'd0);
    cycle();
    chk("r0_wb_l_flag", {31'd0, wb_l_flag}, 32'd0);
    chk("r0_retired", retired, 32'd5);

    // Write-through on a read port in the committing cycle
    idle_inputs();
    mem_if.inst = {NOP_SLOT, 32'h0000_0033};
    mem_if.l_rt = 5'd5; mem_if.l_rt_flag = 1'b1; mem_if.l_tdata = 32'h1234;
    ra0_addr = 5'd5;
    #1 chk("wt_ra0", ra0_data, 32'h1234);
    cycle();

    // Randomized traffic with occasional mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      rstn = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rstn = 1'b1;

    // Counter wrap: preload all-ones, then retire two instructions
    idle_inputs();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    mem_if.inst = {32'h0000_0001, 32'h0000_0002};
    cycle();
    chk("wrap_retired", retired, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
